// File: rtl/syn_bcd_updown_counter.sv
// syn_bcd_updown_counter
//
// Multi-digit synchronous BCD up/down counter with count enable, parallel
// load with per-digit validation, and a combinational terminal-count output
// intended to drive the enable of a downstream stage.
//
// Parameters:
//   DIGITS  number of BCD digits (1..8); digit 0 is q[3:0]
//
// Ports:
//   clk    in   1          rising-edge clock
//   reset  in   1          synchronous reset, active-high (q <= 0, err <= 0)
//   en     in   1          count enable, one step per enabled edge
//   up     in   1          direction: 1 = increment, 0 = decrement
//   load   in   1          parallel-load strobe (beats en, loses to reset)
//   d      in   4*DIGITS   load value, packed BCD; digits > 9 load as 0
//   q      out  4*DIGITS   current count, registered
//   tc     out  1          terminal count, combinational
//   err    out  1          one-cycle pulse after a load holding an invalid digit

module syn_bcd_updown_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  err
);

    logic [4*DIGITS-1:0] r_q;
    logic                r_err;

    logic [DIGITS-1:0]   w_is9;
    logic [DIGITS-1:0]   w_is0;
    logic [4*DIGITS-1:0] w_q_step;
    logic [4*DIGITS-1:0] w_q_load;
    logic                w_load_bad;

    // Per-digit terminal detection, shared by the step chain and tc.
    always_comb begin
        w_is9 = '0;
        w_is0 = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_is9[i] = (r_q[4*i +: 4] == 4'd9);
            w_is0[i] = (r_q[4*i +: 4] == 4'd0);
        end
    end

    // Ripple of "all lower digits at their terminal value": a digit moves
    // only while the chain is still live, then the chain survives only if
    // this digit was itself terminal in the current direction.
    always_comb begin
        logic       w_carry;
        logic [3:0] w_dig;
        w_q_step = r_q;
        w_carry  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_dig = r_q[4*i +: 4];
            if (w_carry) begin
                if (up) begin
                    w_q_step[4*i +: 4] = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
                end else begin
                    w_q_step[4*i +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
                end
            end
            w_carry = w_carry & (up ? w_is9[i] : w_is0[i]);
        end
    end

    // Load sanitisation: any non-BCD nibble loads as 0 and flags err.
    always_comb begin
        logic [3:0] w_nib;
        w_q_load   = '0;
        w_load_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_nib = d[4*i +: 4];
            if (w_nib > 4'd9) begin
                w_q_load[4*i +: 4] = 4'd0;
                w_load_bad         = 1'b1;
            end else begin
                w_q_load[4*i +: 4] = w_nib;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_err <= 1'b0;
        end else if (load) begin
            r_q   <= w_q_load;
            r_err <= w_load_bad;
        end else begin
            r_err <= 1'b0;
            if (en) begin
                r_q <= w_q_step;
            end
        end
    end

    assign q   = r_q;
    assign err = r_err;
    assign tc  = en & ~load & ~reset & (up ? (&w_is9) : (&w_is0));

endmodule

// File: tb/tb_syn_bcd_updown_counter.sv
module tb_syn_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] d;
    logic [7:0] q;
    logic       tc, err;

    logic       c_reset, c_en, c_up;
    logic [3:0] c_q0, c_q1;
    logic       c_tc0, c_tc1, c_err0, c_err1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    syn_bcd_updown_counter #(.DIGITS(2)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .d(d), .q(q), .tc(tc), .err(err)
    );

    syn_bcd_updown_counter #(.DIGITS(1)) c_lo (
        .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(1'b0),
        .d(4'h0), .q(c_q0), .tc(c_tc0), .err(c_err0)
    );

    syn_bcd_updown_counter #(.DIGITS(1)) c_hi (
        .clk(clk), .reset(c_reset), .en(c_tc0), .up(c_up), .load(1'b0),
        .d(4'h0), .q(c_q1), .tc(c_tc1), .err(c_err1)
    );

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; d = 8'h00;
        #1;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL reset_tc: got %b expected 0", tc); else n_pass++;
        step();
        step();
        n_checks++;
        if (q !== 8'h00) $display("FAIL reset_q: got %h expected 00", q); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        reset = 1'b0; en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (q !== 8'h00 || err !== 1'b0 || tc !== 1'b0)
                $display("FAIL hold[%0d]: got q=%h err=%b tc=%b expected q=00 err=0 tc=0", k, q, err, tc);
            else n_pass++;
        end
    endtask

    task automatic test_up_count();
        int e = 0;
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            n_checks++;
            if (tc !== (e == 99))
                $display("FAIL up_tc[%0d]: got %b expected %b", e, tc, (e == 99));
            else n_pass++;
            step();
            e = (e + 1) % 100;
            n_checks++;
            if (q !== bcd2(e)) $display("FAIL up_q: got %h expected %h", q, bcd2(e)); else n_pass++;
        end
    endtask

    task automatic test_down_count();
        int e = 0;
        en = 1'b1; up = 1'b0;
        for (int k = 0; k < 11; k++) begin
            #1;
            n_checks++;
            if (tc !== (e == 0))
                $display("FAIL down_tc[%0d]: got %b expected %b", e, tc, (e == 0));
            else n_pass++;
            step();
            e = (e + 99) % 100;
            n_checks++;
            if (q !== bcd2(e)) $display("FAIL down_q: got %h expected %h", q, bcd2(e)); else n_pass++;
        end
        up = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL flip_tc: got %b expected 0", tc); else n_pass++;
        step();
        n_checks++;
        if (q !== 8'h90) $display("FAIL flip_q: got %h expected 90", q); else n_pass++;
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; up = 1'b1; d = 8'h47;
        #1;
        n_checks++;
        if (tc !== 1'b0) $display("FAIL load_tc: got %b expected 0", tc); else n_pass++;
        step();
        n_checks++;
        if (q !== 8'h47 || err !== 1'b0)
            $display("FAIL load_47: got q=%h err=%b expected q=47 err=0", q, err);
        else n_pass++;
        load = 1'b0;
        step();
        n_checks++;
        if (q !== 8'h48) $display("FAIL load_next: got %h expected 48", q); else n_pass++;
        en = 1'b0; load = 1'b1; d = 8'h4A;
        step();
        n_checks++;
        if (q !== 8'h40 || err !== 1'b1)
            $display("FAIL load_4A: got q=%h err=%b expected q=40 err=1", q, err);
        else n_pass++;
        load = 1'b0;
        step();
        n_checks++;
        if (q !== 8'h40 || err !== 1'b0)
            $display("FAIL err_pulse: got q=%h err=%b expected q=40 err=0", q, err);
        else n_pass++;
        load = 1'b1; d = 8'hFF;
        step();
        n_checks++;
        if (q !== 8'h00 || err !== 1'b1)
            $display("FAIL load_FF: got q=%h err=%b expected q=00 err=1", q, err);
        else n_pass++;
        d = 8'hA5;
        step();
        n_checks++;
        if (q !== 8'h05 || err !== 1'b1)
            $display("FAIL load_A5: got q=%h err=%b expected q=05 err=1", q, err);
        else n_pass++;
        d = 8'h99;
        step();
        n_checks++;
        if (q !== 8'h99 || err !== 1'b0)
            $display("FAIL load_99: got q=%h err=%b expected q=99 err=0", q, err);
        else n_pass++;
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; d = 8'h22; en = 1'b0; up = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        step();
        n_checks++;
        if (q !== 8'h23) $display("FAIL mid_23: got %h expected 23", q); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (q !== 8'h00 || tc !== 1'b0)
            $display("FAIL mid_reset: got q=%h tc=%b expected q=00 tc=0", q, tc);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (q !== 8'h01) $display("FAIL mid_resume: got %h expected 01", q); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_cascade();
        int e = 0;
        c_reset = 1'b1; c_en = 1'b0; c_up = 1'b1;
        step();
        c_reset = 1'b0; c_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            e++;
        end
        n_checks++;
        if ({c_q1, c_q0} !== 8'h25)
            $display("FAIL casc_25: got %h expected 25", {c_q1, c_q0});
        else n_pass++;
        for (int k = 0; k < 74; k++) begin
            step();
            e++;
            n_checks++;
            if ({c_q1, c_q0} !== bcd2(e))
                $display("FAIL casc_q: got %h expected %h", {c_q1, c_q0}, bcd2(e));
            else n_pass++;
        end
        n_checks++;
        if (c_tc0 !== 1'b1 || c_tc1 !== 1'b1)
            $display("FAIL casc_tc99: got tc0=%b tc1=%b expected 1 1", c_tc0, c_tc1);
        else n_pass++;
        step();
        n_checks++;
        if ({c_q1, c_q0} !== 8'h00 || c_err0 !== 1'b0 || c_err1 !== 1'b0)
            $display("FAIL casc_wrap: got %h expected 00", {c_q1, c_q0});
        else n_pass++;
        c_en = 1'b0;
    endtask

    initial begin
        c_reset = 1'b1; c_en = 1'b0; c_up = 1'b1;
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_reset_mid();
        test_cascade();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
